// File: rtl/text_pkg.sv
// Shared constants and types for the text writer: geometry defaults,
// the ASCII control codes the writer reacts to, and the state enum.
package text_pkg;

   localparam int COLS_DEFAULT   = 80;
   localparam int ROWS_DEFAULT   = 60;
   localparam int STRIDE_DEFAULT = 256;

   localparam logic [7:0] CODE_CR    = 8'h0D;
   localparam logic [7:0] CODE_LF    = 8'h0A;
   localparam logic [7:0] CODE_BS    = 8'h08;
   localparam logic [7:0] CODE_FF    = 8'h0C;
   localparam logic [7:0] CODE_SPACE = 8'h20;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLRLINE = 2'd1,
      CLRSCRN = 2'd2
   } state_t;

endpackage

// File: rtl/text_writer.sv
// Character-stream terminal writer: turns a byte stream into writes to a
// character RAM, tracking a cursor and clearing lines/screen with spaces.
module text_writer
   import text_pkg::*;
#(
   parameter int COLS   = COLS_DEFAULT,
   parameter int ROWS   = ROWS_DEFAULT,
   parameter int STRIDE = STRIDE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [14:0] wr_addr,
   output logic [6:0]  wr_data,
   output logic [6:0]  cursor_col,
   output logic [6:0]  cursor_row,
   output logic        busy
);

   localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
   localparam logic [6:0]  ROW_LAST = 7'(ROWS - 1);
   localparam logic [6:0]  COL_END  = 7'(COLS);
   localparam logic [6:0]  ROW_END  = 7'(ROWS);
   localparam logic [14:0] STRIDE_W = 15'(STRIDE);

   state_t     state;
   logic [6:0] clr_col;
   logic [6:0] clr_row;
   logic       printable;
   logic [6:0] next_row;

   // Character-RAM address of a (row, col) cell.
   function automatic logic [14:0] addr_of(input logic [6:0] r, input logic [6:0] c);
      return 15'(r) * STRIDE_W + 15'(c);
   endfunction

   // Handshake/status decode and the row a newline or wrap moves to.
   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
      next_row  = (cursor_row == ROW_LAST) ? 7'd0 : cursor_row + 7'd1;
   end

   // Main FSM: byte interpretation in IDLE, space-fill sequencer in the clear
   // states. The clear states linger one cycle after their last write so
   // in_ready only rises once the final write has been presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLRSCRN;
         clr_col    <= 7'd0;
         clr_row    <= 7'd0;
         cursor_col <= 7'd0;
         cursor_row <= 7'd0;
         wr_en      <= 1'b0;
         wr_addr    <= 15'd0;
         wr_data    <= 7'd0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (printable) begin
                     wr_en   <= 1'b1;
                     wr_addr <= addr_of(cursor_row, cursor_col);
                     wr_data <= in_data[6:0];
                     if (cursor_col == COL_LAST) begin
                        cursor_col <= 7'd0;
                        cursor_row <= next_row;
                        clr_col    <= 7'd0;
                        state      <= CLRLINE;
                     end else begin
                        cursor_col <= cursor_col + 7'd1;
                     end
                  end else if (in_data == CODE_CR) begin
                     cursor_col <= 7'd0;
                  end else if (in_data == CODE_LF) begin
                     cursor_col <= 7'd0;
                     cursor_row <= next_row;
                     clr_col    <= 7'd0;
                     state      <= CLRLINE;
                  end else if (in_data == CODE_BS) begin
                     if (cursor_col != 7'd0) begin
                        cursor_col <= cursor_col - 7'd1;
                     end
                  end else if (in_data == CODE_FF) begin
                     cursor_col <= 7'd0;
                     cursor_row <= 7'd0;
                     clr_col    <= 7'd0;
                     clr_row    <= 7'd0;
                     state      <= CLRSCRN;
                  end
               end
            end
            CLRLINE: begin
               if (clr_col != COL_END) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr_of(cursor_row, clr_col);
                  wr_data <= CODE_SPACE[6:0];
                  clr_col <= clr_col + 7'd1;
               end else begin
                  state <= IDLE;
               end
            end
            CLRSCRN: begin
               if (clr_row != ROW_END) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr_of(clr_row, clr_col);
                  wr_data <= CODE_SPACE[6:0];
                  if (clr_col == COL_LAST) begin
                     clr_col <= 7'd0;
                     clr_row <= clr_row + 7'd1;
                  end else begin
                     clr_col <= clr_col + 7'd1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer at default geometry.
module tb_text_writer;

   localparam int COLS   = 80;
   localparam int ROWS   = 60;
   localparam int STRIDE = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [6:0]  wr_data;
   logic [6:0]  cursor_col;
   logic [6:0]  cursor_row;
   logic        busy;

   int checks = 0;
   int errors = 0;

   text_writer #(.COLS(COLS), .ROWS(ROWS), .STRIDE(STRIDE)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .cursor_col(cursor_col),
      .cursor_row(cursor_row),
      .busy(busy)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where outputs are stable.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One comparison: count it, and report tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one byte, waiting (bounded) for in_ready, and return just after the
   // transfer edge so the resulting registered outputs are visible.
   task automatic applyStimulus(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 2000) begin
         step();
         n++;
      end
      if (n >= 2000) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   // Wait (bounded) until the writer is idle again.
   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 6000) begin
         step();
         n++;
      end
      if (n >= 6000) checkOutput({tag, "_idle_timeout"}, 32'(in_ready), 32'd1);
   endtask

   // Expect a full-screen space fill starting on the next edge, then idle.
   task automatic checkScreenClear(input string tag);
      int bad;
      int early;
      bad   = 0;
      early = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            step();
            if (wr_en !== 1'b1 || wr_addr !== 15'(r * 256 + c) || wr_data !== 7'h20) bad++;
            if (in_ready !== 1'b0) early++;
         end
      end
      checkOutput({tag, "_bad_writes"}, 32'(bad), 32'd0);
      checkOutput({tag, "_early_ready"}, 32'(early), 32'd0);
      step();
      checkOutput({tag, "_ready_after"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_wr_en_after"}, 32'(wr_en), 32'd0);
      checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   // Directed sequence covering reset, printing, wrap, newline, backspace,
   // other codes and an asynchronous reset in the middle of a screen clear.
   initial begin
      int bad;
      int max_addr;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // Reset state.
      step();
      step();
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd1);
      checkOutput("rst_cursor", {18'd0, cursor_row, cursor_col}, 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("rst_wr_data", 32'(wr_data), 32'd0);

      // Release reset: full clear precedes the first in_ready.
      rst = 1'b0;
      checkScreenClear("boot_clear");

      // "AB" on consecutive cycles.
      applyStimulus(8'h41);
      checkOutput("A_wr_en", 32'(wr_en), 32'd1);
      checkOutput("A_addr", 32'(wr_addr), 32'd0);
      checkOutput("A_data", 32'(wr_data), 32'h41);
      applyStimulus(8'h42);
      checkOutput("B_wr_en", 32'(wr_en), 32'd1);
      checkOutput("B_addr", 32'(wr_addr), 32'd1);
      checkOutput("B_data", 32'(wr_data), 32'h42);
      checkOutput("AB_cursor_col", 32'(cursor_col), 32'd2);
      checkOutput("AB_cursor_row", 32'(cursor_row), 32'd0);

      // Unrecognised bytes are swallowed without effect.
      applyStimulus(8'h01);
      checkOutput("ctl01_wr_en", 32'(wr_en), 32'd0);
      checkOutput("ctl01_cursor_col", 32'(cursor_col), 32'd2);
      applyStimulus(8'h7F);
      checkOutput("del_wr_en", 32'(wr_en), 32'd0);
      checkOutput("del_cursor_col", 32'(cursor_col), 32'd2);

      // CR returns to column 0 without a write.
      applyStimulus(8'h0D);
      checkOutput("cr_wr_en", 32'(wr_en), 32'd0);
      checkOutput("cr_cursor_col", 32'(cursor_col), 32'd0);
      checkOutput("cr_cursor_row", 32'(cursor_row), 32'd0);

      // 80 printables: last at column 79, then wrap and clear row 1.
      for (int i = 0; i < 80; i++) begin
         applyStimulus(8'(8'h30 + (i % 10)));
      end
      checkOutput("wrap_last_addr", 32'(wr_addr), 32'd79);
      checkOutput("wrap_last_data", 32'(wr_data), 32'h39);
      checkOutput("wrap_last_wr_en", 32'(wr_en), 32'd1);
      checkOutput("wrap_cursor", {18'd0, cursor_row, cursor_col}, {18'd0, 7'd1, 7'd0});
      bad = 0;
      for (int c = 0; c < COLS; c++) begin
         step();
         if (wr_en !== 1'b1 || wr_addr !== 15'(256 + c) || wr_data !== 7'h20) bad++;
      end
      checkOutput("wrap_clrline_bad", 32'(bad), 32'd0);
      step();
      checkOutput("wrap_busy_after", 32'(busy), 32'd0);
      checkOutput("wrap_wr_en_after", 32'(wr_en), 32'd0);

      // Walk down to the last row with LFs.
      for (int i = 0; i < 58; i++) begin
         applyStimulus(8'h0A);
      end
      waitIdle("lf_walk");
      checkOutput("row59_cursor_row", 32'(cursor_row), 32'd59);

      // LF on the last row wraps to row 0 and clears it.
      applyStimulus(8'h0A);
      checkOutput("lf59_wr_en", 32'(wr_en), 32'd0);
      checkOutput("lf59_cursor", {18'd0, cursor_row, cursor_col}, 32'd0);
      checkOutput("lf59_busy", 32'(busy), 32'd1);
      bad      = 0;
      max_addr = 0;
      for (int c = 0; c < COLS; c++) begin
         step();
         if (wr_en !== 1'b1 || wr_addr !== 15'(c) || wr_data !== 7'h20) bad++;
         if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
      end
      checkOutput("lf59_clrline_bad", 32'(bad), 32'd0);
      checkOutput("lf59_addr_in_range", 32'(max_addr < 15184), 32'd1);
      step();
      checkOutput("lf59_idle", 32'(in_ready), 32'd1);

      // Backspace at column 0, then X, BS, Y overwriting cell 0.
      applyStimulus(8'h08);
      checkOutput("bs0_wr_en", 32'(wr_en), 32'd0);
      checkOutput("bs0_cursor_col", 32'(cursor_col), 32'd0);
      applyStimulus(8'h58);
      checkOutput("X_addr", 32'(wr_addr), 32'd0);
      checkOutput("X_data", 32'(wr_data), 32'h58);
      applyStimulus(8'h08);
      checkOutput("bs1_wr_en", 32'(wr_en), 32'd0);
      checkOutput("bs1_cursor_col", 32'(cursor_col), 32'd0);
      applyStimulus(8'h59);
      checkOutput("Y_wr_en", 32'(wr_en), 32'd1);
      checkOutput("Y_addr", 32'(wr_addr), 32'd0);
      checkOutput("Y_data", 32'(wr_data), 32'h59);
      checkOutput("Y_cursor", {18'd0, cursor_row, cursor_col}, {18'd0, 7'd0, 7'd1});

      // FF from a non-home position, abort with reset at the 2000th write.
      applyStimulus(8'h5A);
      applyStimulus(8'h0C);
      checkOutput("ff_cursor", {18'd0, cursor_row, cursor_col}, 32'd0);
      checkOutput("ff_busy", 32'(busy), 32'd1);
      checkOutput("ff_wr_en", 32'(wr_en), 32'd0);
      bad = 0;
      for (int k = 0; k < 2000; k++) begin
         step();
         if (wr_en !== 1'b1 || wr_addr !== 15'((k / 80) * 256 + (k % 80))) bad++;
      end
      checkOutput("ff_partial_bad", 32'(bad), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort_wr_en_async", 32'(wr_en), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd1);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
      checkOutput("abort_wr_addr", 32'(wr_addr), 32'd0);
      step();
      step();
      rst = 1'b0;
      checkScreenClear("restart_clear");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
